// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with a valid/ready byte output.
// Framing errors are reported and the line is parked until it returns high.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low sample on os_tick
// S_START | qualifying the start bit at its midpoint
// S_DATA  | sampling data bits at mid-bit, LSB first
// S_STOP  | sampling the stop bit, delivering or flagging the byte
// S_BRK   | stop bit was low; wait for the line to return high
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Acceptance; a delivery in the same cycle below overrides this.
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (os_tick && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (os_tick) begin
          if (cnt_q == CNT_HALF) begin
            if (!rx_s) begin
              state_d  = S_DATA;
              cnt_d    = '0;
              bitcnt_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DATA: begin
        if (os_tick) begin
          if (cnt_q == CNT_LAST) begin
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d    = '0;
            bitcnt_d = bitcnt_q + BW'(1);
            if (bitcnt_q == BIT_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_STOP: begin
        if (os_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
              // The consumer may free the slot in the very cycle the byte lands.
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              state_d     = S_BRK;
              frame_err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_BRK: begin
        if (os_tick && rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_serial;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 16x oversampling, os_tick every 4 clk,
// frames driven bit-by-bit with a 64-clk bit period.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       os_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  int tick_div = 0;
  logic [7:0] got_q[$];
  logic prev_valid = 1'b0;
  event start_ev;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      os_tick  = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  // A new byte lands when valid is high after an edge where the slot was empty
  // or being accepted (rx_ready here is the value seen at that edge).
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1 && (prev_valid !== 1'b1 || rx_ready === 1'b1))
      got_q.push_back(rx_data);
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
    prev_valid = rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got time %0t required below 1000000", $time);
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_serial = 1'b0;
    -> start_ev;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", rx_valid); end
  endtask

  task automatic test_basic();
    got_q.delete(); fe_cnt = 0; ov_cnt = 0;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    idle(BIT_CLK);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", got_q[0]); end
    end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL basic_frame_err got %0d want 0", fe_cnt); end
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL basic_overrun got %0d want 0", ov_cnt); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    got_q.delete(); fe_cnt = 0;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (16) @(negedge clk);
    rx_serial = 1'b1;
    idle(200);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_no_byte got %0d want 0", got_q.size()); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", rx_valid); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_cnt); end
    send_frame(8'h3C, 1'b1);
    idle(BIT_CLK);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL glitch_next_count got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h3C) begin errors++; $display("FAIL glitch_next_data got %h want 3c", got_q[0]); end
    end
  endtask

  task automatic test_frame_err();
    got_q.delete(); fe_cnt = 0; ov_cnt = 0;
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0);
    repeat (40 * BIT_CLK) @(negedge clk);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL ferr_no_byte got %0d want 0", got_q.size()); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", rx_valid); end
    rx_serial = 1'b1;
    idle(2 * BIT_CLK);
    send_frame(8'h81, 1'b1);
    idle(BIT_CLK);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_next_count got %0d want 1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data got %h want 81", got_q[0]); end
    end
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_after got %0d want 1", fe_cnt); end
  endtask

  task automatic test_overrun();
    got_q.delete(); ov_cnt = 0; fe_cnt = 0;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(BIT_CLK);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept got %h want 11", rx_data); end
    checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ov_cnt); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ovr_count got %0d want 1", got_q.size()); end
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b want 0", rx_valid); end
    send_frame(8'h33, 1'b1);
    idle(BIT_CLK);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL ovr_third_count got %0d want 2", got_q.size()); end
    else begin
      checks++; if (got_q[1] !== 8'h33) begin errors++; $display("FAIL ovr_third_data got %h want 33", got_q[1]); end
    end
  endtask

  // Raise rx_ready only for the edge that samples the 0x22 stop bit:
  // detect tick + 8 start ticks + 128 data ticks + 16 stop ticks.
  task automatic test_ready_on_delivery();
    int n;
    bit found;
    got_q.delete(); ov_cnt = 0;
    rx_ready = 1'b0;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        @(start_ev);
        @(start_ev);
        repeat (3) @(posedge clk);
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (os_tick) begin found = 1'b1; break; end
          @(posedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rod_tick_search got none want tick within 8 clk"); end
        n = 0;
        while (n < 151) begin
          @(posedge clk);
          if (os_tick) n++;
        end
        repeat (4) @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rod_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL rod_data got %h want 22", rx_data); end
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(BIT_CLK);
    checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL rod_overrun got %0d want 0", ov_cnt); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL rod_data_hold got %h want 22", rx_data); end
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL rod_count got %0d want 2", got_q.size()); end
    rx_ready = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_mid_frame();
    got_q.delete(); ov_cnt = 0; fe_cnt = 0;
    rx_ready = 1'b0;
    send_frame(8'hC3, 1'b1);
    idle(BIT_CLK);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got %b want 1", rx_valid); end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(start_ev);
        repeat (5 * BIT_CLK + 32) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", overrun); end
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(3 * BIT_CLK);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_partial got %b want 0", rx_valid); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rmid_count got %0d want 1", got_q.size()); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL rmid_fe got %0d want 0", fe_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h5A; exp_b[3] = 8'h96;
    got_q.delete(); ov_cnt = 0; fe_cnt = 0;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    idle(BIT_CLK);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_q[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], exp_b[i]); end
      end
    end
    checks++; if (ov_cnt !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL b2b_flags got ov=%0d fe=%0d want 0 0", ov_cnt, fe_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ready_on_delivery();
    test_reset_mid_frame();
    test_back_to_back();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL fe_ov_same_cycle got %0d want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
